// File: rtl/tx_stream_pkg.sv
// Shared definitions for the Tx frame streamer: FSM encoding, default frame geometry
// and the CRC-12 constants plus a one-word parallel CRC update.
package tx_stream_pkg;

    localparam int unsigned DEF_WORDS_PER_LINE = 80;
    localparam int unsigned DEF_LINES          = 480;
    localparam int unsigned DEF_FRAME_WORDS    = DEF_WORDS_PER_LINE * DEF_LINES;
    localparam int unsigned DEF_SYNC_LEN       = 4;
    localparam int unsigned DEF_LINE_GAP       = 16;

    localparam logic [11:0] CRC12_POLY = 12'h80F;
    localparam logic [11:0] CRC12_INIT = 12'hFFF;

    typedef enum logic [2:0] {
        StIdle,
        StFsync,
        StData,
        StCrc,
        StLsync,
        StGap,
        StDone
    } tx_state_e;

    // Advance the CRC over one 12-bit word, MSB first, no reflection.
    function automatic logic [11:0] crc12_next(input logic [11:0] crc, input logic [11:0] data);
        logic [11:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            if (c[11] ^ data[i]) begin
                c = {c[10:0], 1'b0} ^ CRC12_POLY;
            end else begin
                c = {c[10:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_crc12.sv
// Line CRC-12 accumulator: one word per cycle, synchronous clear to the init value.
module tx_crc12
    import tx_stream_pkg::*;
(
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [11:0] data_i,
    output logic [11:0] crc_o
);

    logic [11:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC12_INIT;
        end else if (en_i) begin
            crc_d = crc12_next(crc_q, data_i);
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= CRC12_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/tx_frame_streamer.sv
// Frame buffer plus streamer: FraimSync, per-line data words, LineSync terminator, line gap.
// Optional per-line CRC-12 word after the data is enabled by defining TX_LINE_CRC_EN.
module tx_frame_streamer
    import tx_stream_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned SYNC_LEN       = DEF_SYNC_LEN,
    parameter int unsigned LINE_GAP       = DEF_LINE_GAP
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        CamWe,
    input  logic [15:0] CamAdd,
    input  logic [11:0] CamData,
    input  logic        StartFrame,
    input  logic        Abort,
    output logic        Busy,
    output logic        FrameDone,
    output logic        FraimSync,
    output logic        LineSync,
    output logic [11:0] TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        TxCrc,
    output logic [8:0]  LineCnt
);

    localparam int unsigned FRAME_WORDS = WORDS_PER_LINE * LINES;

`ifdef TX_LINE_CRC_EN
    localparam tx_state_e AfterData = StCrc;
`else
    localparam tx_state_e AfterData = StLsync;
`endif

    tx_state_e   state_q, state_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [8:0]  line_q, line_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic [7:0]  fetched_q, fetched_d;
    logic [7:0]  sent_q, sent_d;
    logic        rd_vld_q, rd_vld_d;
    logic        out_vld_q, out_vld_d;
    logic [11:0] out_data_q, out_data_d;
    logic        skid_vld_q, skid_vld_d;
    logic [11:0] skid_data_q, skid_data_d;
    logic [11:0] rd_data_q;
    logic [11:0] mem [FRAME_WORDS];

    logic        abort_act;
    logic        pop;
    logic        fetch;
    logic [1:0]  occ;

    // No arbitration: a same-address write and read sees the old word.
    always_ff @(posedge Cclk) begin
        if (CamWe && (CamAdd < 16'(FRAME_WORDS))) begin
            mem[CamAdd] <= CamData;
        end
        if (fetch) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign abort_act = Abort && (state_q != StIdle);
    assign pop       = (state_q == StData) && out_vld_q && TxReady;
    assign occ       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q);

    // Words held or in flight never exceed the two prefetch slots.
    assign fetch = (state_q == StData) && !Abort && (fetched_q != 8'(WORDS_PER_LINE)) &&
                   ((occ - 2'(pop)) < 2'd2);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        line_d    = line_q;
        rd_addr_d = rd_addr_q;
        fetched_d = fetched_q;
        sent_d    = sent_q;

        unique case (state_q)
            StIdle: begin
                if (StartFrame && !Abort) begin
                    state_d = StFsync;
                    tmr_d   = 8'd0;
                end
            end
            StFsync: begin
                rd_addr_d = 16'd0;
                line_d    = 9'd0;
                fetched_d = 8'd0;
                sent_d    = 8'd0;
                if (tmr_q == 8'(SYNC_LEN - 1)) begin
                    state_d = StData;
                    tmr_d   = 8'd0;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StData: begin
                if (fetch) begin
                    fetched_d = fetched_q + 8'd1;
                    if (rd_addr_q != 16'(FRAME_WORDS - 1)) begin
                        rd_addr_d = rd_addr_q + 16'd1;
                    end
                end
                if (pop) begin
                    if (sent_q == 8'(WORDS_PER_LINE - 1)) begin
                        sent_d  = 8'd0;
                        state_d = AfterData;
                        tmr_d   = 8'd0;
                    end else begin
                        sent_d = sent_q + 8'd1;
                    end
                end
            end
`ifdef TX_LINE_CRC_EN
            StCrc: begin
                if (TxReady) begin
                    state_d = StLsync;
                    tmr_d   = 8'd0;
                end
            end
`endif
            StLsync: begin
                if (tmr_q == 8'(SYNC_LEN - 1)) begin
                    state_d = StGap;
                    tmr_d   = 8'd0;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StGap: begin
                fetched_d = 8'd0;
                if (tmr_q == 8'(LINE_GAP - 1)) begin
                    tmr_d = 8'd0;
                    if (line_q == 9'(LINES - 1)) begin
                        state_d = StDone;
                    end else begin
                        line_d  = line_q + 9'd1;
                        state_d = StData;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                line_d  = 9'd0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_act) begin
            state_d   = StIdle;
            tmr_d     = 8'd0;
            line_d    = 9'd0;
            rd_addr_d = 16'd0;
            fetched_d = 8'd0;
            sent_d    = 8'd0;
        end
    end

    // Output register refills from skid first, then from the memory read port.
    always_comb begin
        rd_vld_d    = fetch;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;

        if (pop) begin
            if (skid_vld_q) begin
                out_data_d  = skid_data_q;
                skid_vld_d  = rd_vld_q;
                skid_data_d = rd_data_q;
            end else begin
                out_vld_d  = rd_vld_q;
                out_data_d = rd_data_q;
            end
        end else if (rd_vld_q) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = rd_data_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = rd_data_q;
            end
        end

        if (abort_act) begin
            rd_vld_d   = 1'b0;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            tmr_q       <= 8'd0;
            line_q      <= 9'd0;
            rd_addr_q   <= 16'd0;
            fetched_q   <= 8'd0;
            sent_q      <= 8'd0;
            rd_vld_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= 12'd0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= 12'd0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            line_q      <= line_d;
            rd_addr_q   <= rd_addr_d;
            fetched_q   <= fetched_d;
            sent_q      <= sent_d;
            rd_vld_q    <= rd_vld_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef TX_LINE_CRC_EN
    logic        crc_clr;
    logic [11:0] crc_val;

    assign crc_clr = (state_q == StFsync) || (state_q == StGap);

    tx_crc12 u_crc (
        .Cclk   (Cclk),
        .rstn   (rstn),
        .clr_i  (crc_clr),
        .en_i   (pop),
        .data_i (out_data_q),
        .crc_o  (crc_val)
    );

    assign TxValid = out_vld_q || (state_q == StCrc);
    assign TxData  = out_vld_q ? out_data_q : ((state_q == StCrc) ? crc_val : 12'd0);
    assign TxCrc   = (state_q == StCrc);
`else
    assign TxValid = out_vld_q;
    assign TxData  = out_vld_q ? out_data_q : 12'd0;
    assign TxCrc   = 1'b0;
`endif

    assign Busy      = (state_q != StIdle) && (state_q != StDone);
    assign FrameDone = (state_q == StDone);
    assign FraimSync = (state_q == StFsync);
    assign LineSync  = (state_q == StLsync);
    assign LineCnt   = line_q;

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Directed-plus-random bench for tx_frame_streamer with a frame-level reference model
// and a receiver model that rebuilds the frame from the Tx outputs.
module tb_tx_frame_streamer;

    localparam int WPL   = 80;
    localparam int NLINE = 480;
    localparam int FW    = WPL * NLINE;
    localparam int SYNC  = 4;
    localparam int GAP   = 16;
`ifdef TX_LINE_CRC_EN
    localparam int LW = WPL + 1;
`else
    localparam int LW = WPL;
`endif

    logic        Cclk = 1'b0;
    logic        rstn = 1'b0;
    logic        CamWe = 1'b0;
    logic [15:0] CamAdd = 16'd0;
    logic [11:0] CamData = 12'd0;
    logic        StartFrame = 1'b0;
    logic        Abort = 1'b0;
    logic        TxReady = 1'b0;
    logic        Busy, FrameDone, FraimSync, LineSync, TxValid, TxCrc;
    logic [11:0] TxData;
    logic [8:0]  LineCnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] src [FW];
    logic [11:0] rx  [FW];
    int          ra;
    logic [11:0] rv;

    tx_frame_streamer dut (
        .Cclk       (Cclk),
        .rstn       (rstn),
        .CamWe      (CamWe),
        .CamAdd     (CamAdd),
        .CamData    (CamData),
        .StartFrame (StartFrame),
        .Abort      (Abort),
        .Busy       (Busy),
        .FrameDone  (FrameDone),
        .FraimSync  (FraimSync),
        .LineSync   (LineSync),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .TxCrc      (TxCrc),
        .LineCnt    (LineCnt)
    );

    always #5 Cclk = ~Cclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {5'd0, Busy, FrameDone, FraimSync, LineSync, TxValid, TxCrc, TxData, LineCnt};
    endfunction

`ifdef TX_LINE_CRC_EN
    function automatic logic [11:0] crc_line(input int base);
        logic [11:0] r;
        logic [11:0] w;
        logic        fb;
        r = 12'hFFF;
        for (int k = 0; k < WPL; k++) begin
            w = src[base + k];
            for (int b = 11; b >= 0; b--) begin
                fb = r[11] ^ w[b];
                r  = r << 1;
                if (fb) r = r ^ 12'h80F;
            end
        end
        return r;
    endfunction
`endif

    // Streams one frame (optionally aborted on word 39 of line 2) and checks it cycle by cycle.
    task automatic run_frame(input bit do_abort);
        int exp_idx = 0, line_words = 0, lines_done = 0, rx_ptr = 0, rx_cnt = 0;
        int fs_run = 0, ls_run = 0, fd_cnt = 0, cyc = 0, fs_fall = -1, ls_fall = -1;
        int probe = -1, abort_at = -1, ns, bad;
        bit first_valid = 1'b1, fin = 1'b0, stall = 1'b0, ready, done_seen = 1'b0;
        logic [11:0] stall_data = 12'd0;

        StartFrame = 1'b1;
        @(negedge Cclk);
        StartFrame = 1'b0;
        chk("fsync_first", 32'(FraimSync), 1);
        chk("start_line", 32'(LineCnt), 0);
        chk("start_busy", 32'(Busy), 1);

        while (!fin && cyc < 60000) begin
            StartFrame = 1'b0;
            ns = int'(FraimSync) + int'(LineSync) + int'(TxValid);
            chk("mutex", 32'(ns <= 1), 1);
            if (abort_at >= 0) begin
                if (cyc == abort_at + 1) begin
                    chk("abort_outs", outs(), 0);
                    Abort = 1'b0;
                end else begin
                    chk("abort_idle", 32'({FrameDone, Busy, TxValid}), 0);
                end
                if (cyc == abort_at + 20) fin = 1'b1;
            end else begin
                if (FraimSync) begin
                    fs_run++;
                end else if (fs_run > 0 && fs_fall < 0) begin
                    chk("fsync_len", fs_run, SYNC);
                    fs_fall = cyc;
                end
                if (LineSync) begin
                    if (ls_run == 0) chk("line_words", line_words, LW);
                    ls_run++;
                end else if (ls_run > 0) begin
                    chk("lsync_len", ls_run, SYNC);
                    ls_run      = 0;
                    ls_fall     = cyc;
                    lines_done++;
                    line_words  = 0;
                    rx_ptr      = rx_ptr + WPL;
                    rx_cnt      = 0;
                    first_valid = 1'b1;
                end
                if (stall) begin
                    chk("stall_valid", 32'(TxValid), 1);
                    chk("stall_data", 32'(TxData), 32'(stall_data));
                end
                if (TxValid && first_valid) begin
                    first_valid = 1'b0;
                    if (lines_done == 0) chk("first_lat", cyc - fs_fall, 2);
                    else chk("gap_len", cyc - ls_fall, GAP + 2);
                end
                if (TxValid) chk("linecnt", 32'(LineCnt), lines_done);
                chk("txcrc", 32'(TxCrc), 32'(TxValid && (line_words == WPL)));
                if (done_seen) begin
                    chk("done_pulse", 32'({Busy, FrameDone, FraimSync, LineSync, TxValid, TxCrc}), 0);
                    fin = 1'b1;
                end else if (FrameDone) begin
                    fd_cnt++;
                    done_seen = 1'b1;
                    chk("done_lines", lines_done, NLINE);
                    chk("done_gap", cyc - ls_fall, GAP);
                end

                ready = (lines_done == 5) ? ($urandom_range(0, 2) == 0) : 1'b1;
                if (do_abort && TxValid && lines_done == 2 && line_words == 39) begin
                    Abort    = 1'b1;
                    abort_at = cyc;
                end
                if (!do_abort && probe < 0 && lines_done == 100 && line_words == 10) begin
                    StartFrame = 1'b1;
                    probe      = cyc;
                end
                if (probe >= 0 && cyc == probe + 5) begin
                    chk("sf_ign_busy", 32'(Busy), 1);
                    chk("sf_ign_line", 32'(LineCnt), 100);
                end
                stall = 1'b0;
                if (TxValid && abort_at < 0) begin
                    if (ready) begin
                        if (line_words < WPL) begin
                            chk("data", 32'(TxData), 32'(src[exp_idx]));
                            if (rx_ptr + rx_cnt < FW) rx[rx_ptr + rx_cnt] = TxData;
                            rx_cnt++;
                            exp_idx++;
                        end
`ifdef TX_LINE_CRC_EN
                        else chk("crc_word", 32'(TxData), 32'(crc_line(lines_done * WPL)));
`endif
                        line_words++;
                    end else begin
                        stall      = 1'b1;
                        stall_data = TxData;
                    end
                end
                TxReady = ready;
            end
            cyc++;
            @(negedge Cclk);
        end

        chk("frame_end", 32'(fin), 1);
        if (do_abort) begin
            chk("abort_no_done", fd_cnt, 0);
        end else begin
            chk("done_count", fd_cnt, 1);
            chk("rx_addr", rx_ptr, 32'h9600);
            bad = 0;
            for (int i = 0; i < FW; i++) if (rx[i] !== src[i]) bad++;
            chk("rx_frame", bad, 0);
            chk("line0_first", 32'(rx[0]), 32'h000);
            chk("line0_last", 32'(rx[79]), 32'h04F);
            chk("line5_first", 32'(rx[400]), 32'h190);
            chk("line5_last", 32'(rx[479]), 32'h1DF);
            chk("line479_first", 32'(rx[38320]), 32'h5B0);
            chk("line479_last", 32'(rx[38399]), 32'h5FF);
        end
    endtask

    initial begin
        repeat (3) @(negedge Cclk);
        chk("reset_outs", outs(), 0);
        rstn = 1'b1;
        @(negedge Cclk);
        chk("idle_outs", outs(), 0);

        for (int a = 0; a < FW; a++) begin
            CamWe   = 1'b1;
            CamAdd  = 16'(a);
            CamData = 12'(a);
            src[a]  = 12'(a);
            @(negedge Cclk);
        end
        // Random overwrites away from the lines whose exact contents are checked.
        for (int k = 0; k < 16; k++) begin
            ra      = $urandom_range(6 * WPL, 479 * WPL - 1);
            rv      = 12'($urandom);
            CamAdd  = 16'(ra);
            CamData = rv;
            src[ra] = rv;
            @(negedge Cclk);
        end
        CamWe = 1'b0;
        chk("fill_idle", outs(), 0);

        TxReady = 1'b1;
        run_frame(1'b1);

        for (int i = 0; i < FW; i++) rx[i] = 'x;
        TxReady = 1'b1;
        run_frame(1'b0);

        StartFrame = 1'b1;
        Abort      = 1'b1;
        @(negedge Cclk);
        StartFrame = 1'b0;
        Abort      = 1'b0;
        chk("sf_abort_busy", 32'({Busy, FraimSync}), 0);
        @(negedge Cclk);
        chk("sf_abort_hold", 32'({Busy, FraimSync, TxValid}), 0);

        StartFrame = 1'b1;
        @(negedge Cclk);
        StartFrame = 1'b0;
        repeat (30) @(negedge Cclk);
        chk("pre_rst_busy", 32'(Busy), 1);
        #2 rstn = 1'b0;
        #1 chk("async_rst", outs(), 0);
        @(negedge Cclk);
        rstn = 1'b1;
        @(negedge Cclk);
        chk("post_rst_idle", outs(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
